decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode stage; sits between fetch and execute. Accepts {pc, instr} from fetch
//  (valid/ready) and drives register-file read addresses in the accept cycle. Because
//  register reads are synchronous, the read data arrives one cycle later, aligned with the
//  registered decode bundle. Produces rd, sign-extended immediate and field decode, and
//  flags illegal encodings.
// PARAMETERS
//  PC_WIDTH        32  width of program counter carried through the stage
//  ILLEGAL_AS_NOP  0   1: illegal instr delivered with rd forced 0 and id_illegal=1; 0: same but rd kept
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-low reset
//  flush           in   1   squash held/arriving instruction (branch redirect)
//  if_valid        in   1   fetch presents instruction
//  if_ready        out  1   stage can accept this cycle
//  if_pc           in   PC_WIDTH  pc of presented instruction
//  if_instr        in   32  presented instruction word
//  rf_rs1_addr     out  5   register-file read address 1 (combinational)
//  rf_rs2_addr     out  5   register-file read address 2 (combinational)
//  rf_rs1_data     in   32  register-file read data 1 (valid 1 cycle after address)
//  rf_rs2_data     in   32  register-file read data 2
//  id_valid        out  1   decode bundle valid
//  id_ready        in   1   execute accepts bundle
//  id_pc/id_instr  out  PC_WIDTH/32  held pc and raw instruction
//  id_opcode/id_funct3/id_funct7  out  7/3/7  decoded fields
//  id_rd           out  5   destination; 0 for S/B-type (no writeback)
//  id_imm          out  32  sign-extended immediate per format (0 for R-type)
//  id_rs1_data/id_rs2_data  out  32  pass-through of rf_rs*_data
//  id_illegal      out  1   opcode not RV32I or instr[1:0]!=2'b11
// BEHAVIOUR
//  - Reset (async, low): id_valid=0, id_pc/id_instr/id_imm=0, id_rd=0, id_illegal=0; if_ready=1 once released.
//  - if_ready = !flush && (!id_valid || id_ready). accept = if_valid && if_ready.
//  - Accept: register pc, instr, decode; id_valid<=1 next cycle. Latency 1 cycle.
//  - id_valid && id_ready && !accept -> id_valid<=0. flush -> id_valid<=0 (priority over all).
//  - rf addresses: if_ready ? fields of if_instr : fields of held id_instr. During a stall the
//    held addresses are re-presented each cycle so id_rs*_data tracks later writebacks.
//  - rs1 forced 0 for U/J (LUI, AUIPC, JAL); rs2 forced 0 for U/J/I formats (incl. loads,
//    JALR, OP-IMM, SYSTEM, MISC-MEM). Illegal instr: both forced 0.
//  - Formats: I (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011, MISC-MEM 0001111),
//    S 0100011, B 1100011, U (LUI 0110111, AUIPC 0010111), J 1101111, R 0110011.
//  - Immediates sign-extend from instr[31]; B/J bit 0 = 0; U low 12 bits = 0.
//  - id_rs*_data is combinational pass-through; valid whenever id_valid=1.
//  - Simultaneous drain+accept: bundle replaced with no bubble. flush+if_valid: instr dropped.
//  - Reset mid-stall: bundle discarded, no id_valid pulse after release.
// TESTING
//  1 Reset low while id_valid=1 and stalled -> id_valid=0 immediately; after release if_ready=1.
//  2 Accept 0xFFD08293 (ADDI x5,x1,-3) pc=0x100 -> rf_rs1_addr=1, rf_rs2_addr=0 in accept cycle;
//    next cycle id_valid=1, id_rd=5, id_imm=0xFFFFFFFD, id_pc=0x100.
//  3 Hold 0x002081B3 (ADD x3,x1,x2) with id_ready=0 for 3 cycles, write x1=0xA5 mid-stall ->
//    if_ready=0, addresses stay 1/2, id_rs1_data=0xA5 the cycle after the write.
//  4 Assert flush with if_valid=1 and a held bundle -> next cycle id_valid=0, nothing accepted.
//  5 Immediates: 0xFE000EE3 (BEQ -4) -> imm 0xFFFFFFFC, rd 0; 0x001000EF (JAL x1,+2048) ->
//    imm 0x00000800, rd 1, rs1 0; 0x123453B7 (LUI x7) -> imm 0x12345000.
//  6 Back-to-back stream of 4 instrs with id_ready=1 -> id_valid held 1 for 4 cycles, no bubbles;
//    0x00000000 -> id_illegal=1, rf addrs 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage between fetch and execute.
// Accepts {pc, instr} over valid/ready, presents register-file read addresses in the
// accept cycle, and holds a registered decode bundle (rd, immediate, field decode,
// illegal flag) whose register operands arrive from the synchronous register file
// one cycle after the address, aligned with the bundle.
module decode_stage #(
  parameter int PC_WIDTH       = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic [31:0]         if_instr,
  output logic [4:0]          rf_rs1_addr,
  output logic [4:0]          rf_rs2_addr,
  input  logic [31:0]         rf_rs1_data,
  input  logic [31:0]         rf_rs2_data,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_instr,
  output logic [6:0]          id_opcode,
  output logic [2:0]          id_funct3,
  output logic [6:0]          id_funct7,
  output logic [4:0]          id_rd,
  output logic [31:0]         id_imm,
  output logic [31:0]         id_rs1_data,
  output logic [31:0]         id_rs2_data,
  output logic                id_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction format class; FMT_X marks an encoding outside RV32I.
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  // Full 7-bit opcode match, so instr[1:0]!=2'b11 falls out as FMT_X.
  function automatic fmt_e fmt_of(input logic [31:0] w);
    case (w[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC: return FMT_I;
      OP_STORE:                                     return FMT_S;
      OP_BRANCH:                                    return FMT_B;
      OP_LUI, OP_AUIPC:                             return FMT_U;
      OP_JAL:                                       return FMT_J;
      OP_REG:                                       return FMT_R;
      default:                                      return FMT_X;
    endcase
  endfunction

  function automatic logic signed [31:0] sext12(input logic signed [11:0] v);
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] sext13(input logic signed [12:0] v);
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] sext21(input logic signed [20:0] v);
    return 32'(v);
  endfunction

  // Immediate reassembly per format; B/J carry an implicit zero LSB.
  function automatic logic signed [31:0] imm_of(input logic [31:0] w);
    case (fmt_of(w))
      FMT_I:   return sext12(w[31:20]);
      FMT_S:   return sext12({w[31:25], w[11:7]});
      FMT_B:   return sext13({w[31], w[7], w[30:25], w[11:8], 1'b0});
      FMT_U:   return $signed({w[31:12], 12'h000});
      FMT_J:   return sext21({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: return '0;
    endcase
  endfunction

  // Stores and branches never write back, so their rd field is not a destination.
  function automatic logic [4:0] rd_of(input logic [31:0] w);
    case (fmt_of(w))
      FMT_S, FMT_B: return 5'd0;
      FMT_X:        return ILLEGAL_AS_NOP ? 5'd0 : w[11:7];
      default:      return w[11:7];
    endcase
  endfunction

  // Unused source fields read x0 so the register file sees no spurious reads.
  function automatic logic [4:0] rs1_of(input logic [31:0] w);
    case (fmt_of(w))
      FMT_U, FMT_J, FMT_X: return 5'd0;
      default:             return w[19:15];
    endcase
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] w);
    case (fmt_of(w))
      FMT_R, FMT_S, FMT_B: return w[24:20];
      default:             return 5'd0;
    endcase
  endfunction

  logic                vld_p1;
  logic [PC_WIDTH-1:0] pc_p1;
  logic [31:0]         instr_p1;
  logic [4:0]          rd_p1;
  logic signed [31:0]  imm_p1;
  logic                ill_p1;

  logic                accept_p0;
  logic [31:0]         addr_src_p0;

  assign if_ready  = !flush && (!vld_p1 || id_ready);
  assign accept_p0 = if_valid && if_ready;

  // Stalled bundle keeps re-presenting its own addresses so later writebacks are seen.
  assign addr_src_p0 = if_ready ? if_instr : instr_p1;
  assign rf_rs1_addr = rs1_of(addr_src_p0);
  assign rf_rs2_addr = rs2_of(addr_src_p0);

  // ---- p0 -> p1: accept boundary ----

  // Bundle valid: flush wins, then a new accept, then drain by execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
    end else if (id_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Capture pc, raw instruction and decoded fields on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p1    <= '0;
      instr_p1 <= '0;
      rd_p1    <= '0;
      imm_p1   <= '0;
      ill_p1   <= 1'b0;
    end else if (accept_p0) begin
      pc_p1    <= if_pc;
      instr_p1 <= if_instr;
      rd_p1    <= rd_of(if_instr);
      imm_p1   <= imm_of(if_instr);
      ill_p1   <= (fmt_of(if_instr) == FMT_X);
    end
  end

  assign id_valid    = vld_p1;
  assign id_pc       = pc_p1;
  assign id_instr    = instr_p1;
  assign id_opcode   = instr_p1[6:0];
  assign id_funct3   = instr_p1[14:12];
  assign id_funct7   = instr_p1[31:25];
  assign id_rd       = rd_p1;
  assign id_imm      = imm_p1;
  assign id_illegal  = ill_p1;
  assign id_rs1_data = rf_rs1_data;
  assign id_rs2_data = rf_rs2_data;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a randomized
// stream, with a scoreboard fed by a handshake model and drained by an output monitor.
module tb_decode_stage;

  localparam bit ILL_NOP = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rd;
  logic [31:0] id_imm, id_rs1_data, id_rs2_data;
  logic        id_illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(.PC_WIDTH(32), .ILLEGAL_AS_NOP(ILL_NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_imm(id_imm), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // Register file model with synchronous read; writes happen just after the falling edge.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t q[$];

  // Reference decode written from the format table using plain integer arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    byte  f;
    int   v;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: f = "I";
      7'h23: f = "S";
      7'h63: f = "B";
      7'h37, 7'h17: f = "U";
      7'h6F: f = "J";
      7'h33: f = "R";
      default: f = "X";
    endcase
    v = 0;
    case (f)
      "I": begin v = int'(w[31:20]); if (w[31]) v -= 4096; end
      "S": begin v = int'(w[31:25]) * 32 + int'(w[11:7]); if (w[31]) v -= 4096; end
      "B": begin
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      "U": v = int'(w[31:12]) * 4096;
      "J": begin
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v -= 1048576;
      end
      default: v = 0;
    endcase
    e.pc    = pc;
    e.instr = w;
    e.imm   = 32'(v);
    e.ill   = (f == "X");
    e.rd    = (f == "S" || f == "B" || (f == "X" && ILL_NOP)) ? 5'd0 : w[11:7];
    e.rs1   = (f == "U" || f == "J" || f == "X") ? 5'd0 : w[19:15];
    e.rs2   = (f == "R" || f == "S" || f == "B") ? w[24:20] : 5'd0;
    return e;
  endfunction

  // Handshake model: checks ready/valid/addresses and pushes expected bundles on accept.
  logic        mvld;
  logic [31:0] held;
  always @(negedge clk) begin
    logic exp_rdy, acc;
    exp_t a;
    if (!reset) begin
      mvld = 1'b0;
      held = '0;
      q.delete();
    end else begin
      chk("id_valid", id_valid, mvld);
      exp_rdy = !flush && (!mvld || id_ready);
      chk("if_ready", if_ready, exp_rdy);
      a = ref_dec('0, exp_rdy ? if_instr : held);
      chk("rf_rs1_addr", rf_rs1_addr, a.rs1);
      chk("rf_rs2_addr", rf_rs2_addr, a.rs2);
      acc = if_valid && exp_rdy;
      if (acc) begin
        q.push_back(ref_dec(if_pc, if_instr));
        held = if_instr;
      end
      if (flush)         mvld = 1'b0;
      else if (acc)      mvld = 1'b1;
      else if (id_ready) mvld = 1'b0;
    end
  end

  // Output monitor: pops on each handshake and discards the bundle squashed by flush.
  always @(negedge clk) begin
    exp_t e;
    if (reset && id_valid) begin
      if (flush) begin
        if (q.size() != 0) void'(q.pop_front());
      end else if (id_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: bundle presented with nothing expected at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          chk("id_opcode", id_opcode, e.instr[6:0]);
          chk("id_funct3", id_funct3, e.instr[14:12]);
          chk("id_funct7", id_funct7, e.instr[31:25]);
          chk("id_rd", id_rd, e.rd);
          chk("id_imm", id_imm, e.imm);
          chk("id_illegal", id_illegal, e.ill);
          chk("id_rs1_data", id_rs1_data, regs[e.rs1]);
          chk("id_rs2_data", id_rs2_data, regs[e.rs2]);
        end
      end
    end
  end

  localparam logic [31:0] I_ADDI = 32'hFFD08293;
  localparam logic [31:0] I_ADD  = 32'h002081B3;

  logic [31:0] stream   [4] = '{32'hFE000EE3, 32'h001000EF, 32'h123453B7, 32'h00000000};
  logic [31:0] s_imm    [4] = '{32'hFFFFFFFC, 32'h00000800, 32'h12345000, 32'h00000000};
  logic [4:0]  s_rd     [4] = '{5'd0, 5'd1, 5'd7, 5'd0};
  logic        s_ill    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0]  opcodes [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h01010101 * i;
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; id_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("if_ready after reset", if_ready, 1'b1);
    chk("id_valid after reset", id_valid, 1'b0);

    // ADDI x5,x1,-3 accepted with id_ready high
    @(posedge clk); #1;
    if_valid = 1'b1; if_pc = 32'h100; if_instr = I_ADDI; id_ready = 1'b1;
    #1 chk("addi rs1 addr", rf_rs1_addr, 5'd1);
    chk("addi rs2 addr", rf_rs2_addr, 5'd0);
    @(posedge clk); #1 if_valid = 1'b0;
    #1 chk("addi valid", id_valid, 1'b1);
    chk("addi rd", id_rd, 5'd5);
    chk("addi imm", id_imm, 32'hFFFFFFFD);
    chk("addi pc", id_pc, 32'h100);

    // ADD x3,x1,x2 held in a stall while x1 is rewritten
    @(posedge clk); #1;
    if_valid = 1'b1; if_pc = 32'h104; if_instr = I_ADD;
    @(posedge clk); #1 if_valid = 1'b0; id_ready = 1'b0;
    #1 chk("stall if_ready", if_ready, 1'b0);
    chk("stall rs1 addr", rf_rs1_addr, 5'd1);
    chk("stall rs2 addr", rf_rs2_addr, 5'd2);
    @(negedge clk); #1 regs[1] = 32'hA5;
    @(posedge clk); #2;
    chk("stall rs1 data after write", id_rs1_data, 32'hA5);
    chk("stall rs1 addr held", rf_rs1_addr, 5'd1);
    chk("stall rs2 addr held", rf_rs2_addr, 5'd2);

    // Reset while a bundle is stalled
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("async reset id_valid", id_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("release if_ready", if_ready, 1'b1);
    chk("release id_valid", id_valid, 1'b0);
    @(posedge clk); #1 chk("no pulse after release", id_valid, 1'b0);

    // Flush with a held bundle and an arriving instruction
    if_valid = 1'b1; if_pc = 32'h200; if_instr = I_ADDI; id_ready = 1'b0;
    @(posedge clk); #1 if_instr = I_ADD; if_pc = 32'h204; flush = 1'b1;
    #1 chk("flush if_ready", if_ready, 1'b0);
    chk("flush held valid", id_valid, 1'b1);
    @(posedge clk); #1 flush = 1'b0; if_valid = 1'b0;
    #1 chk("flush id_valid", id_valid, 1'b0);

    // Back-to-back stream: immediates and an illegal all-zero word
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b1; if_instr = stream[k]; if_pc = 32'h300 + 32'(4 * k);
      if (k == 3) begin
        #1 chk("illegal rs1 addr", rf_rs1_addr, 5'd0);
        chk("illegal rs2 addr", rf_rs2_addr, 5'd0);
      end
      @(posedge clk); #1;
      if (k == 3) if_valid = 1'b0;
      #1 chk("stream valid", id_valid, 1'b1);
      chk("stream imm", id_imm, s_imm[k]);
      chk("stream rd", id_rd, s_rd[k]);
      chk("stream illegal", id_illegal, s_ill[k]);
    end
    @(posedge clk); #1 chk("stream end valid", id_valid, 1'b0);

    // Randomized traffic with backpressure, flushes and register writes
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom & 32'hFFFFFFFC;
      if_instr = $urandom;
      if ($urandom_range(0, 7) != 0) if_instr[6:0] = opcodes[$urandom_range(0, 10)];
      flush    = ($urandom_range(0, 15) == 0);
      id_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
      if ($urandom_range(0, 2) == 0) regs[$urandom_range(1, 31)] = $urandom;
    end

    @(posedge clk); #1 if_valid = 1'b0; flush = 1'b0; id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("scoreboard drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
